// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO feeding a UART serializer with start bit, 8 data bits
//            (LSB first), optional even parity, and 1..15 stop bits.
// Options  : define UART_TX_PARITY_EN to insert an even-parity bit after
//            the data bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_i,        // UART_CLK
    input  logic       rst_ni,       // RESET, asynchronous active-low
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic [3:0] stop_bits_i,
    output logic       full_o,
    output logic       empty_o,
    output logic       overflow_o,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       uart_out_o
);

    localparam int         AW          = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [AW:0] PTR_ONE     = (AW + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
        ,
        ST_PARITY = 3'd3
`endif
    } state_e;

    // ------------------------------------------------------------------
    // FIFO storage and pointers (one extra wrap bit for full/empty)
    // ------------------------------------------------------------------
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        overflow_q;
    logic        pop;
    logic        push;
    logic [7:0]  head;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle frees a slot, so a write to a full FIFO is kept.
    assign push    = wr_en_i && (!full_o || pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow_o = overflow_q;

    // Byte storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Pointer advance and dropped-write flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            overflow_q <= wr_en_i && full_o && !pop;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;     // cycles left in the current bit
    logic [3:0]  bit_q, bit_d;       // data bit index, or stop bits remaining
    logic [7:0]  shreg_q, shreg_d;
    logic [3:0]  stop_q, stop_d;     // stop-bit count latched at frame start
    logic        line_q, line_d;
    logic        load;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    assign bit_end    = (baud_q == 16'd0);
    assign tx_busy_o  = (state_q != ST_IDLE);
    assign uart_out_o = line_q;

    // Next-state, counter and pop decisions; the line level is precomputed
    // for the next state so the serial output is glitch-free from a flop.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        stop_d    = stop_q;
        pop       = 1'b0;
        load      = 1'b0;
        tx_done_o = 1'b0;
        line_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                load = !empty_o;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 4'd0;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 4'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
                        bit_d   = stop_q - 4'd1;
`endif
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = stop_q - 4'd1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_q == 4'd0) begin
                        tx_done_o = 1'b1;
                        state_d   = ST_IDLE;
                        load      = !empty_o;
                    end else begin
                        bit_d  = bit_q - 4'd1;
                        baud_d = BAUD_RELOAD;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame start: from IDLE, or straight out of the last stop bit.
        if (load) begin
            pop     = 1'b1;
            state_d = ST_START;
            shreg_d = head;
            stop_d  = (stop_bits_i == 4'd0) ? 4'd1 : stop_bits_i;
            baud_d  = BAUD_RELOAD;
            bit_d   = 4'd0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
        end

        case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_d = parity_d;
`endif
            default:   line_d = 1'b1;
        endcase
    end

    // FSM and datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            stop_q   <= '0;
            line_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            stop_q   <= stop_d;
            line_q   <= line_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Scoreboard bench for uart_tx_fifo (CLK_DIV=4, FIFO_DEPTH=8).
//            Expected frames are queued by the stimulus; a line monitor
//            decodes each frame and compares it against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // Offset (in cycles) of the first stop-bit cycle from the start-bit cycle.
    localparam int S = CLK_DIV * (9 + P);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [3:0] stop_bits = 4'd1;
    wire        full, empty, overflow, tx_busy, tx_done, uart;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .stop_bits_i(stop_bits),
        .full_o     (full),
        .empty_o    (empty),
        .overflow_o (overflow),
        .tx_busy_o  (tx_busy),
        .tx_done_o  (tx_done),
        .uart_out_o (uart)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         len;
        bit         b2b;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h required=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int flen(input int sb);
        return S + CLK_DIV * ((sb == 0) ? 1 : sb);
    endfunction

    task automatic push_exp(input logic [7:0] d, input int sb, input bit b2b);
        exp_t e;
        e.data = d;
        e.len  = flen(sb);
        e.b2b  = b2b;
        sb_q.push_back(e);
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (!(empty && !tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", {30'd0, empty, tx_busy}, 32'h2);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Line monitor: decodes frames on the falling edge and scores them
    // ------------------------------------------------------------------
    int         cyc = 0;
    int         last_done = -100;
    bit         m_act = 0;
    int         m_pos = 0;
    int         m_gap = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_par = 1'b0;
    bit         m_busy_bad = 0;
    bit         m_shape_bad = 0;
    exp_t       m_e;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_act = 0;
        end else if (!m_act) begin
            if (tx_done) begin
                checks++;
                errors++;
                $display("FAIL done_outside_frame: got tx_done=1 required 0 (t=%0t)", $time);
            end
            if (uart == 1'b0) begin
                m_act       = 1;
                m_pos       = 0;
                m_data      = 8'h00;
                m_par       = 1'b0;
                m_busy_bad  = !tx_busy;
                m_shape_bad = 0;
                m_gap       = cyc - last_done;
            end
        end else begin
            m_pos++;
            if (!tx_busy) m_busy_bad = 1;
            if (m_pos < CLK_DIV && uart != 1'b0) m_shape_bad = 1;
            for (int k = 1; k <= 8; k++) begin
                if (m_pos == CLK_DIV * k + CLK_DIV / 2) m_data[k-1] = uart;
            end
            if (m_pos == CLK_DIV * 9 + CLK_DIV / 2) m_par = uart;
            if (m_pos >= S && uart != 1'b1) m_shape_bad = 1;
            if (tx_done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got data=%02h, required no frame", m_data);
                end else begin
                    m_e = sb_q.pop_front();
                    chk("frame_data", {24'd0, m_data}, {24'd0, m_e.data});
                    chk("frame_len", m_pos + 1, m_e.len);
                    chk("frame_busy_shape", {30'd0, m_busy_bad, m_shape_bad}, 32'd0);
`ifdef UART_TX_PARITY_EN
                    chk("frame_parity", {31'd0, m_par}, {31'd0, ^m_e.data});
`endif
                    if (m_e.b2b) chk("frame_gap", m_gap, 1);
                end
                last_done = cyc;
                m_act     = 0;
            end else if (m_pos > S + 16 * CLK_DIV) begin
                checks++;
                errors++;
                $display("FAIL frame_timeout: got no tx_done after %0d cycles, required end of frame", m_pos);
                m_act = 0;
            end
        end
    end

    function automatic logic exp_line(input int c, input logic [7:0] d);
        if (c < 2)                return 1'b1;
        if (c < 2 + CLK_DIV)      return 1'b0;
        if (c < 2 + 9 * CLK_DIV)  return d[(c - 2 - CLK_DIV) / CLK_DIV];
        if (P == 1 && c < 2 + 10 * CLK_DIV) return ^d;
        return 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] fill [8];
        int         n;
        bit         bad_u;
        bit         bad_b;
        int         dcyc;
        logic [3:0] e4;

        fill[0] = 8'hD0; fill[1] = 8'hD1; fill[2] = 8'h3A; fill[3] = 8'hC5;
        fill[4] = 8'h00; fill[5] = 8'hFF; fill[6] = 8'h81; fill[7] = 8'h7E;

        // Reset state, checked asynchronously before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_uart", {31'd0, uart}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame 0xA5, cycle-exact: write in cycle 0.
        dcyc    = S + CLK_DIV + 1;
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        push_exp(8'hA5, 1, 0);
        for (int c = 0; c < dcyc + 4; c++) begin
            @(negedge clk);
            e4 = {exp_line(c, 8'hA5),
                  (c >= 2 && c <= dcyc) ? 1'b1 : 1'b0,
                  (c == dcyc) ? 1'b1 : 1'b0,
                  (c == 1) ? 1'b0 : 1'b1};
            chk($sformatf("a5_cyc%0d_uart_busy_done_empty", c),
                {28'd0, uart, tx_busy, tx_done, empty}, {28'd0, e4});
            @(posedge clk);
            #1;
            wr_en = 1'b0;
        end
        wait_idle(50);

        // Fill the FIFO behind an in-flight frame, then overflow it.
        write_byte(8'hF0);
        push_exp(8'hF0, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = fill[i];
            push_exp(fill[i], 1, 1);
            @(posedge clk);
            #1;
        end
        wr_data = 8'hEE;     // ninth byte: must be dropped
        @(negedge clk);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_no_ovf_yet", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("ovf_pulse", {31'd0, overflow}, 32'd1);
        chk("ovf_full_kept", {31'd0, full}, 32'd1);
        @(negedge clk);
        chk("ovf_pulse_end", {31'd0, overflow}, 32'd0);

        // Write on the exact pop cycle while full: accepted as 9th frame.
        n = 0;
        while (!tx_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pop_cycle_done", {31'd0, tx_done}, 32'd1);
        chk("pop_cycle_full", {31'd0, full}, 32'd1);
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        push_exp(8'h3C, 1, 1);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("pop_write_full", {31'd0, full}, 32'd1);
        chk("pop_write_no_ovf", {31'd0, overflow}, 32'd0);
        wait_idle(600);

        // Stop-bit count: 0 behaves as 1, then 3 and 15.
        stop_bits = 4'd0;
        write_byte(8'h81);
        push_exp(8'h81, 0, 0);
        wait_idle(200);
        stop_bits = 4'd3;
        write_byte(8'h42);
        push_exp(8'h42, 3, 0);
        wait_idle(200);
        stop_bits = 4'd15;
        write_byte(8'h18);
        push_exp(8'h18, 15, 0);
        wait_idle(200);

        // Mid-frame STOP_BITS change only affects the following frame.
        stop_bits = 4'd2;
        write_byte(8'h99);
        push_exp(8'h99, 2, 0);
        repeat (9) @(posedge clk);
        #1;
        stop_bits = 4'd5;
        write_byte(8'h66);
        push_exp(8'h66, 5, 1);
        wait_idle(300);
        stop_bits = 4'd1;

        // Reset during data bit 3 with a second byte queued.
        write_byte(8'h00);
        write_byte(8'h55);
        repeat (17) @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_uart_low", {31'd0, uart}, 32'd0);
        chk("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_uart", {31'd0, uart}, 32'd1);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad_u = 0;
        bad_b = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (uart != 1'b1) bad_u = 1;
            if (tx_busy || !empty) bad_b = 1;
        end
        chk("post_rst_line_idle", {31'd0, bad_u}, 32'd0);
        chk("post_rst_fifo_idle", {31'd0, bad_b}, 32'd0);
        @(posedge clk);
        #1;

`ifdef UART_TX_PARITY_EN
        // Parity frame: 0x07 has three ones, so the parity bit is 1.
        write_byte(8'h07);
        push_exp(8'h07, 1, 0);
        wait_idle(100);
`endif

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_DIV, default 16, UART_CLK cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, byte entries; power of two, 2..64.
REQ-003 UART_CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 WR_EN  input  1  byte-write strobe from the PCI target register stage.
REQ-006 WR_DATA  input  8  byte to transmit; sampled when WR_EN=1.
REQ-007 STOP_BITS  input  4  stop-bit count; 0 is treated as 1; sampled at frame start.
REQ-008 FULL  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-009 EMPTY  output  1  FIFO holds zero bytes.
REQ-010 OVERFLOW  output  1  one-cycle pulse when a write is dropped.
REQ-011 TX_BUSY  output  1  high while a frame is on the line.
REQ-012 TX_DONE  output  1  one-cycle pulse on the cycle the last stop bit ends.
REQ-013 UART_OUT  output  1  serial line; idle high.

Function
REQ-014 FIFO SHALL be circular, with write and read pointers one bit wider than log2(FIFO_DEPTH); FULL/EMPTY derive from pointer compare and are registered-pointer based.
REQ-015 WR_EN with FULL=0 SHALL store the byte; EMPTY SHALL fall on the next cycle.
REQ-016 WR_EN with FULL=1 and no pop in the same cycle SHALL drop the byte and pulse OVERFLOW on the next cycle.
REQ-017 WR_EN with FULL=1 and a pop in the same cycle SHALL accept the write; occupancy stays FIFO_DEPTH.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-019 IDLE with EMPTY=0 SHALL pop one byte into the shift register, latch STOP_BITS, load the bit counter, and enter START; UART_OUT goes low the following cycle.
REQ-020 Each bit SHALL last exactly CLK_DIV cycles, timed by a counter that reloads at every bit boundary.
REQ-021 START drives 0; DATA drives 8 bits LSB first; STOP drives 1 for STOP_BITS bit times.
REQ-022 At the end of STOP, TX_DONE pulses; with EMPTY=0 the FSM pops immediately and enters START with no idle bit; otherwise it enters IDLE.
REQ-023 TX_BUSY SHALL be high in START, DATA, PARITY and STOP, and low in IDLE.
REQ-024 A write to an empty FIFO SHALL put the start bit on UART_OUT 2 cycles after the WR_EN cycle.
REQ-025 Changes to STOP_BITS mid-frame SHALL NOT affect the current frame.

Reset
REQ-026 RESET=0 SHALL immediately force: FSM=IDLE, pointers=0, EMPTY=1, FULL=0, OVERFLOW=0, TX_BUSY=0, TX_DONE=0, UART_OUT=1, all counters=0.
REQ-027 Reset mid-frame SHALL abort the frame; UART_OUT returns high asynchronously and queued bytes are discarded.
REQ-028 The first action after RESET deasserts SHALL occur on the following rising edge of UART_CLK.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: the PARITY state is inserted between DATA and STOP and drives even parity (XOR of the 8 data bits) for one bit time.
REQ-030 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

Verification
REQ-031 Use CLK_DIV=4, STOP_BITS=1, no parity. Write 0xA5 at cycle 0. UART_OUT is low for cycles 2-5, then shows bits 1,0,1,0,0,1,0,1 at 4 cycles each, then is high for 4 cycles. TX_DONE pulses at cycle 41. TX_BUSY is high for cycles 2-41.
REQ-032 Fill 8 bytes back-to-back, then write a 9th. FULL=1, OVERFLOW pulses once, and the 9th byte is never transmitted. The 8 frames are emitted in order with no gaps.
REQ-033 With FULL=1, assert WR_EN on the exact pop cycle. The byte is accepted, FULL stays 1, and it is transmitted as the 9th frame.
REQ-034 Set STOP_BITS=0, then 3. Measure the stop-bit high time: 4 cycles, then 12 cycles. Change STOP_BITS mid-frame: the current frame is unchanged.
REQ-035 Assert RESET low during DATA bit 3. UART_OUT is 1 and EMPTY is 1 within the same cycle. After release, no residual frame is sent.
REQ-036 With UART_TX_PARITY_EN defined, write 0x07. The parity bit is 1 and the frame is 44 cycles long.
